branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The module SHALL have parameter BTBSIZE, default 4, meaning log2 of the BTB entry count (16 entries).
REQ-002 The module SHALL have parameter BHTSIZE, default 6, meaning log2 of the BHT counter count (64 counters).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-005 The module SHALL have port i_bp_flush, input, 1, which cancels the in-flight prediction.
REQ-006 The module SHALL have port i_bp_req, input, 1, a fetch-side prediction request.
REQ-007 The module SHALL have port i_bp_pc, input, 32, the PC being predicted.
REQ-008 The module SHALL have port o_bp_pred_v, output, 1, prediction valid.
REQ-009 The module SHALL have port o_bp_pred_hit, output, 1, BTB tag hit.
REQ-010 The module SHALL have port o_bp_pred_taken, output, 1, predicted taken; it drives the BRT issue taken_pre field.
REQ-011 The module SHALL have port o_bp_pred_target, output, 32, predicted next PC; it drives the BRT issue target_pre field.
REQ-012 The module SHALL have port o_bp_pred_is_ret, output, 1, hit entry marked as return.
REQ-013 The module SHALL have ports i_btb_write_en/1, i_btb_write_pc/32, i_btb_write_target/32 and i_btb_write_is_ret/1, all inputs, forming the BTB update from branch-table commit.
REQ-014 The module SHALL have ports i_bht_write_en/1, i_bht_write_pc/32 and i_bht_write_taken/1, all inputs, forming the BHT update from branch-table commit.

Function
REQ-015 The BTB index SHALL be PC[BTBSIZE+1:2] and the BTB tag SHALL be PC[31:BTBSIZE+2]; each entry SHALL hold valid, tag, target and is_ret.
REQ-016 The BHT index SHALL be PC[BHTSIZE+1:2]; each entry SHALL be a 2-bit saturating counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-017 Prediction latency SHALL be exactly 1 cycle: i_bp_req=1 at edge N SHALL cause o_bp_pred_* to be registered and valid from edge N+1 until edge N+2.
REQ-018 o_bp_pred_v SHALL be 1 for one cycle per request, and 0 in every cycle that has no request.
REQ-019 The hit condition SHALL be entry valid and tag equal; on a hit, target SHALL be the stored target, is_ret the stored bit, and taken SHALL be counter[1] OR is_ret.
REQ-020 On a miss, hit SHALL be 0, taken 0, is_ret 0 and target i_bp_pc+4 (modulo 2^32).
REQ-021 When o_bp_pred_v=0, the remaining prediction outputs SHALL be 0.
REQ-022 A BTB write SHALL unconditionally overwrite its indexed entry (valid=1, new tag/target/is_ret), evicting any alias.
REQ-023 A BHT write with taken=1 SHALL increment the counter, saturating at 11; with taken=0 it SHALL decrement, saturating at 00.
REQ-024 BTB and BHT writes SHALL be independent and MAY occur in the same cycle as each other and as a request.
REQ-025 Lookup SHALL be read-before-write: a same-cycle update to the looked-up index SHALL not affect that prediction, and SHALL be visible to a request one cycle later.
REQ-026 i_bp_flush=1 at edge N SHALL force o_bp_pred_v=0 after edge N, including for a same-cycle request; table updates SHALL proceed during flush.

Reset
REQ-027 While rst=1, all BTB valid bits SHALL be 0, all BHT counters 01, and o_bp_pred_v, hit, taken, is_ret and target SHALL be 0.
REQ-028 A reset asserted mid-operation SHALL discard any in-flight prediction and all table contents immediately, without waiting for a clock edge.

Structure
REQ-029 A shared package SHALL hold the BTB entry struct (valid, tag, target, is_ret), the 2-bit counter typedef, and the constants BHT_INIT=2'b01 and PC_STEP=4.
REQ-030 The saturating-counter update SHALL be one sub-module, sat_counter2, combinational with current counter and taken in and next counter out; all state SHALL stay in branch_predictor.

Verification
REQ-031 Verification SHALL cover cold miss: after reset, req pc=0x100 -> next cycle pred_v=1, hit=0, taken=0, target=0x104.
REQ-032 Verification SHALL cover train to taken: BTB write pc=0x100 target=0x200 plus one BHT taken (01->10), then req 0x100 -> hit=1, taken=1, target=0x200.
REQ-033 Verification SHALL cover saturation: 3 taken writes -> counter 11; then 4 not-taken -> 00; then a 5th not-taken stays 00; then 1 taken -> 01 and req predicts taken=0 with target 0x200.
REQ-034 Verification SHALL cover aliasing: BTB write 0x100, then req 0x140 (same index, different tag) -> hit=0, target=0x144; after BTB write 0x140, req 0x100 -> hit=0.
REQ-035 Verification SHALL cover same-cycle conflict: req 0x300 with BTB write 0x300->0x400 in the same cycle -> hit=0 target=0x304; req again next cycle -> hit=1 target=0x400.
REQ-036 Verification SHALL cover flush/reset: req with i_bp_flush=1 -> pred_v=0 next cycle; rst pulsed mid-stream -> pred_v drops at once and req 0x200 afterwards -> hit=0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor: BTB entry layout,
// 2-bit BHT counter type and the reset / fall-through constants.
package branch_predictor_pkg;

  typedef logic [1:0] cnt2_t;

  localparam cnt2_t       BHT_INIT  = 2'b01;
  localparam logic [31:0] PC_STEP   = 32'd4;
  // Widest tag needed (smallest BTB); narrower tags are zero-extended.
  localparam int          TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic                 is_ret;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat.sv
// Combinational 2-bit saturating counter step used for BHT training.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_nxt
);

  function automatic cnt2_t sat_step(cnt2_t c, logic t);
    cnt2_t r;
    if (t) r = (c == 2'b11) ? c : c + 2'd1;
    else   r = (c == 2'b00) ? c : c - 2'd1;
    return r;
  endfunction

  assign cnt_nxt = sat_step(cnt, taken);

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus bimodal BHT; one-cycle registered prediction with
// read-before-write lookup against same-cycle commit updates.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BTBSIZE = 4,
  parameter int BHTSIZE = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_bp_flush,
  input  logic        i_bp_req,
  input  logic [31:0] i_bp_pc,
  output logic        o_bp_pred_v,
  output logic        o_bp_pred_hit,
  output logic        o_bp_pred_taken,
  output logic [31:0] o_bp_pred_target,
  output logic        o_bp_pred_is_ret,
  input  logic        i_btb_write_en,
  input  logic [31:0] i_btb_write_pc,
  input  logic [31:0] i_btb_write_target,
  input  logic        i_btb_write_is_ret,
  input  logic        i_bht_write_en,
  input  logic [31:0] i_bht_write_pc,
  input  logic        i_bht_write_taken
);

  localparam int BTB_N = 1 << BTBSIZE;
  localparam int BHT_N = 1 << BHTSIZE;

  btb_entry_t btb [BTB_N];
  cnt2_t      bht [BHT_N];

  function automatic logic [TAG_MAX_W-1:0] pc_tag(logic [31:0] pc);
    return TAG_MAX_W'(pc >> (BTBSIZE + 2));
  endfunction

  // Stage p0: combinational lookup on the current request PC
  logic [BTBSIZE-1:0] btb_ridx_p0;
  logic [BHTSIZE-1:0] bht_ridx_p0;
  btb_entry_t         ent_p0;
  logic               hit_p0;
  logic               cnt_msb_p0;
  logic               issue_p0;

  assign btb_ridx_p0 = i_bp_pc[BTBSIZE+1:2];
  assign bht_ridx_p0 = i_bp_pc[BHTSIZE+1:2];
  assign ent_p0      = btb[btb_ridx_p0];
  assign hit_p0      = ent_p0.valid && (ent_p0.tag == pc_tag(i_bp_pc));
  assign cnt_msb_p0  = bht[bht_ridx_p0][1];
  assign issue_p0    = i_bp_req && !i_bp_flush;

  // Commit-side update indices and next counter value
  logic [BTBSIZE-1:0] btb_widx;
  logic [BHTSIZE-1:0] bht_widx;
  logic [1:0]         bht_cur;
  logic [1:0]         bht_nxt;

  assign btb_widx = i_btb_write_pc[BTBSIZE+1:2];
  assign bht_widx = i_bht_write_pc[BHTSIZE+1:2];
  assign bht_cur  = bht[bht_widx];

  sat_counter2 u_sat (
    .cnt     (bht_cur),
    .taken   (i_bht_write_taken),
    .cnt_nxt (bht_nxt)
  );

  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_btb_write_pc[1:0], i_bht_write_pc[31:BHTSIZE+2],
                            i_bht_write_pc[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_N; i++) btb[i] <= '0;
      for (int i = 0; i < BHT_N; i++) bht[i] <= BHT_INIT;
    end else begin
      if (i_btb_write_en)
        btb[btb_widx] <= '{valid:  1'b1,
                           tag:    pc_tag(i_btb_write_pc),
                           target: i_btb_write_target,
                           is_ret: i_btb_write_is_ret};
      if (i_bht_write_en)
        bht[bht_widx] <= bht_nxt;
    end
  end

  // Stage p1: registered prediction outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_bp_pred_v      <= 1'b0;
      o_bp_pred_hit    <= 1'b0;
      o_bp_pred_taken  <= 1'b0;
      o_bp_pred_target <= '0;
      o_bp_pred_is_ret <= 1'b0;
    end else begin
      o_bp_pred_v <= issue_p0;
      if (issue_p0 && hit_p0) begin
        o_bp_pred_hit    <= 1'b1;
        o_bp_pred_taken  <= cnt_msb_p0 || ent_p0.is_ret;
        o_bp_pred_target <= ent_p0.target;
        o_bp_pred_is_ret <= ent_p0.is_ret;
      end else if (issue_p0) begin
        o_bp_pred_hit    <= 1'b0;
        o_bp_pred_taken  <= 1'b0;
        o_bp_pred_target <= i_bp_pc + PC_STEP;
        o_bp_pred_is_ret <= 1'b0;
      end else begin
        o_bp_pred_hit    <= 1'b0;
        o_bp_pred_taken  <= 1'b0;
        o_bp_pred_target <= '0;
        o_bp_pred_is_ret <= 1'b0;
      end
    end
  end

endmodule
